// File: rtl/hpdmc_ctlif_pkg.sv
// hpdmc_ctlif_pkg: shared constants for the HPDMC control interface.
//   - word offsets of the four CSRs (decoded from wbc_adr_i[3:2])
//   - bit positions of the SYS / BYP / TIM / STAT fields
//   - reset defaults of the system control and timing registers
package hpdmc_ctlif_pkg;

  // word offsets
  localparam logic [1:0] ADR_SYS  = 2'd0;
  localparam logic [1:0] ADR_BYP  = 2'd1;
  localparam logic [1:0] ADR_TIM  = 2'd2;
  localparam logic [1:0] ADR_STAT = 2'd3;

  // SYS fields
  localparam int SYS_W      = 3;
  localparam int SYS_BYPASS = 0;
  localparam int SYS_SDRST  = 1;
  localparam int SYS_CKE    = 2;
  localparam logic [SYS_W-1:0] SYS_RST = 3'b011;

  // BYP fields (strobes are active-high in the register)
  localparam int BYP_W       = 19;
  localparam int BYP_CS      = 0;
  localparam int BYP_WE      = 1;
  localparam int BYP_CAS     = 2;
  localparam int BYP_RAS     = 3;
  localparam int BYP_ADR_LSB = 4;
  localparam int BYP_ADR_MSB = 16;
  localparam int BYP_BA_LSB  = 17;
  localparam int BYP_BA_MSB  = 18;

  // TIM register; member order gives the packed bit layout [22:0]
  localparam int TIM_W = 23;
  typedef struct packed {
    logic [1:0]  wr;    // [22:21]
    logic [3:0]  rfc;   // [20:17]
    logic [10:0] refi;  // [16:6]
    logic [2:0]  rcd;   // [5:3]
    logic [2:0]  rp;    // [2:0]
  } tim_t;

  localparam tim_t TIM_RST = '{wr: 2'd2, rfc: 4'd8, refi: 11'd740, rcd: 3'd2, rp: 3'd2};

  // STAT busy flag position
  localparam int STAT_BUSY = 31;

endpackage

// File: rtl/hpdmc_ctlif_guard.sv
// hpdmc_ctlif_guard: loadable saturating down-counter spacing bypass commands.
//   clk_i, rst_ni : clock, async active-low reset
//   load_i        : load reload_i this clock (takes priority over counting)
//   reload_i      : value loaded on load_i
//   busy_o        : count is non-zero
module hpdmc_ctlif_guard #(
  parameter int GUARD_W = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               load_i,
  input  logic [GUARD_W-1:0] reload_i,
  output logic               busy_o
);

  logic [GUARD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)             cnt_d = reload_i;
    else if (cnt_q != '0)   cnt_d = cnt_q - GUARD_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;

  assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/hpdmc_ctlif_slave.sv
// hpdmc_ctlif_slave: Wishbone classic CSR responder for HPDMC.
//   wbc_*      : configuration bus (registered one-clock ack, full-word only)
//   bypass, sdram_rst, sdram_cke : system control outputs (lag SYS by a clock)
//   byp_*      : single-cycle SDRAM command generated by BYP writes in bypass
//   tim_*      : timing fields for the scheduler
module hpdmc_ctlif_slave
  import hpdmc_ctlif_pkg::*;
#(
  parameter int                 CSR_DEPTH_LOG2 = 2,
  parameter int                 GUARD_W        = 8,
  parameter logic [GUARD_W-1:0] GUARD_RST      = GUARD_W'(2)
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic [31:0] wbc_adr_i,
  input  logic [31:0] wbc_dat_i,
  output logic [31:0] wbc_dat_o,
  input  logic [3:0]  wbc_sel_i,
  input  logic        wbc_cyc_i,
  input  logic        wbc_stb_i,
  input  logic        wbc_we_i,
  output logic        wbc_ack_o,
  output logic        bypass,
  output logic        sdram_rst,
  output logic        sdram_cke,
  output logic        byp_cs_n,
  output logic        byp_we_n,
  output logic        byp_cas_n,
  output logic        byp_ras_n,
  output logic [12:0] byp_adr,
  output logic [1:0]  byp_ba,
  output logic [2:0]  tim_rp,
  output logic [2:0]  tim_rcd,
  output logic [10:0] tim_refi,
  output logic [3:0]  tim_rfc,
  output logic [1:0]  tim_wr
);

  logic [CSR_DEPTH_LOG2-1:0] adr;
  logic sel_byp, req, acc, wr, rd, guard_busy;

  logic               ack_q, ack_d;
  logic [31:0]        dat_q, dat_d;
  logic [SYS_W-1:0]   sys_q, sys_d, sys_out_q;
  logic [BYP_W-1:0]   byp_q, byp_d;
  tim_t               tim_q, tim_d;
  logic [GUARD_W-1:0] rel_q, rel_d;
  logic [3:0]         cmd_n_q, cmd_n_d;   // {ras, cas, we, cs}, active low

  logic unused_bits;
  assign unused_bits = ^{wbc_sel_i, wbc_adr_i[31:CSR_DEPTH_LOG2+2], wbc_adr_i[1:0],
                         wbc_dat_i[31:TIM_W]};

  assign adr     = wbc_adr_i[CSR_DEPTH_LOG2+1:2];
  assign sel_byp = (adr == CSR_DEPTH_LOG2'(ADR_BYP));
  // ~ack_q spaces acks so a held strobe completes at most every other clock
  assign req     = wbc_cyc_i & wbc_stb_i & ~ack_q;
  // a BYP write waits until the guard has already reached 0 on this edge
  assign acc     = req & ~(sel_byp & wbc_we_i & guard_busy);
  assign wr      = acc & wbc_we_i;
  assign rd      = acc & ~wbc_we_i;

  hpdmc_ctlif_guard #(.GUARD_W(GUARD_W)) u_guard (
    .clk_i    (sys_clk),
    .rst_ni   (sys_rst_n),
    .load_i   (wr & sel_byp),
    .reload_i (rel_q),
    .busy_o   (guard_busy)
  );

  always_comb begin
    ack_d   = acc;
    dat_d   = '0;
    sys_d   = sys_q;
    byp_d   = byp_q;
    tim_d   = tim_q;
    rel_d   = rel_q;
    cmd_n_d = 4'hF;   // strobes return to deselect after one clock
    if (wr) begin
      case (adr)
        CSR_DEPTH_LOG2'(ADR_SYS):  sys_d = wbc_dat_i[SYS_W-1:0];
        CSR_DEPTH_LOG2'(ADR_BYP): begin
          byp_d = wbc_dat_i[BYP_W-1:0];
          if (sys_out_q[SYS_BYPASS]) cmd_n_d = ~wbc_dat_i[BYP_RAS:BYP_CS];
        end
        CSR_DEPTH_LOG2'(ADR_TIM):  tim_d = tim_t'(wbc_dat_i[TIM_W-1:0]);
        CSR_DEPTH_LOG2'(ADR_STAT): rel_d = wbc_dat_i[GUARD_W-1:0];
        default: ;
      endcase
    end
    if (rd) begin
      case (adr)
        CSR_DEPTH_LOG2'(ADR_SYS):  dat_d = {{(32-SYS_W){1'b0}}, sys_q};
        CSR_DEPTH_LOG2'(ADR_BYP):  dat_d = {{(32-BYP_W){1'b0}}, byp_q};
        CSR_DEPTH_LOG2'(ADR_TIM):  dat_d = {{(32-TIM_W){1'b0}}, tim_q};
        CSR_DEPTH_LOG2'(ADR_STAT): begin
          dat_d            = {{(32-GUARD_W){1'b0}}, rel_q};
          dat_d[STAT_BUSY] = guard_busy;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      ack_q     <= 1'b0;
      dat_q     <= '0;
      sys_q     <= SYS_RST;
      sys_out_q <= SYS_RST;
      byp_q     <= '0;
      tim_q     <= TIM_RST;
      rel_q     <= GUARD_RST;
      cmd_n_q   <= 4'hF;
    end else begin
      ack_q     <= ack_d;
      dat_q     <= dat_d;
      sys_q     <= sys_d;
      sys_out_q <= sys_q;   // SYS outputs change the clock after the ack
      byp_q     <= byp_d;
      tim_q     <= tim_d;
      rel_q     <= rel_d;
      cmd_n_q   <= cmd_n_d;
    end

  assign wbc_ack_o = ack_q;
  assign wbc_dat_o = dat_q;
  assign bypass    = sys_out_q[SYS_BYPASS];
  assign sdram_rst = sys_out_q[SYS_SDRST];
  assign sdram_cke = sys_out_q[SYS_CKE];
  assign byp_cs_n  = cmd_n_q[BYP_CS];
  assign byp_we_n  = cmd_n_q[BYP_WE];
  assign byp_cas_n = cmd_n_q[BYP_CAS];
  assign byp_ras_n = cmd_n_q[BYP_RAS];
  assign byp_adr   = byp_q[BYP_ADR_MSB:BYP_ADR_LSB];
  assign byp_ba    = byp_q[BYP_BA_MSB:BYP_BA_LSB];
  assign tim_rp    = tim_q.rp;
  assign tim_rcd   = tim_q.rcd;
  assign tim_refi  = tim_q.refi;
  assign tim_rfc   = tim_q.rfc;
  assign tim_wr    = tim_q.wr;

endmodule

// File: tb/tb_hpdmc_ctlif_slave.sv
module tb_hpdmc_ctlif_slave;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic [31:0] wbc_adr_i, wbc_dat_i, wbc_dat_o;
  logic [3:0]  wbc_sel_i;
  logic        wbc_cyc_i, wbc_stb_i, wbc_we_i, wbc_ack_o;
  logic        bypass, sdram_rst, sdram_cke;
  logic        byp_cs_n, byp_we_n, byp_cas_n, byp_ras_n;
  logic [12:0] byp_adr;
  logic [1:0]  byp_ba;
  logic [2:0]  tim_rp, tim_rcd;
  logic [10:0] tim_refi;
  logic [3:0]  tim_rfc;
  logic [1:0]  tim_wr;

  hpdmc_ctlif_slave dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .wbc_adr_i(wbc_adr_i), .wbc_dat_i(wbc_dat_i), .wbc_dat_o(wbc_dat_o),
    .wbc_sel_i(wbc_sel_i), .wbc_cyc_i(wbc_cyc_i), .wbc_stb_i(wbc_stb_i),
    .wbc_we_i(wbc_we_i), .wbc_ack_o(wbc_ack_o),
    .bypass(bypass), .sdram_rst(sdram_rst), .sdram_cke(sdram_cke),
    .byp_cs_n(byp_cs_n), .byp_we_n(byp_we_n), .byp_cas_n(byp_cas_n), .byp_ras_n(byp_ras_n),
    .byp_adr(byp_adr), .byp_ba(byp_ba),
    .tim_rp(tim_rp), .tim_rcd(tim_rcd), .tim_refi(tim_refi), .tim_rfc(tim_rfc), .tim_wr(tim_wr)
  );

  always #5 sys_clk = ~sys_clk;

  int edge_n = 0;
  always @(posedge sys_clk) edge_n <= edge_n + 1;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  logic [2:0]  m_sys;
  logic [18:0] m_byp;
  logic [22:0] m_tim;
  logic [7:0]  m_rel;
  int          m_load_e, m_load_v;   // edge of last guard load and value loaded

  function automatic logic [22:0] tim_word(int rp, int rcd, int refi, int rfc, int wr);
    return 23'(rp + rcd * 8 + refi * 64 + rfc * (1 << 17) + wr * (1 << 21));
  endfunction

  task automatic model_reset();
    m_sys = 3'b011; m_byp = '0; m_rel = 8'd2;
    m_tim = tim_word(2, 2, 740, 8, 2);
    m_load_e = -1000; m_load_v = 0;
  endtask

  function automatic int imax(int x, int y);
    return (x > y) ? x : y;
  endfunction

  // earliest edge at which a new BYP write may be accepted
  function automatic int guard_free();
    return m_load_e + m_load_v + 1;
  endfunction

  // guard count visible at edge t (value left by edge t-1)
  function automatic int guard_cnt(int t);
    return imax(0, m_load_v - (t - 1 - m_load_e));
  endfunction

  function automatic logic [31:0] exp_read(logic [1:0] a, int t);
    logic [31:0] r;
    case (a)
      2'd0: r = {29'b0, m_sys};
      2'd1: r = {13'b0, m_byp};
      2'd2: r = {9'b0, m_tim};
      default: r = {(guard_cnt(t) > 0), 23'b0, m_rel};
    endcase
    return r;
  endfunction

  task automatic model_write(logic [1:0] a, logic [31:0] d, int ack_e);
    case (a)
      2'd0: m_sys = d[2:0];
      2'd1: begin m_byp = d[18:0]; m_load_e = ack_e; m_load_v = int'(m_rel); end
      2'd2: m_tim = d[22:0];
      default: m_rel = d[7:0];
    endcase
  endtask

  // ---------------- bus driver ----------------
  // Returns at the negedge inside the ack clock (ack and strobes still high/low).
  task automatic wb(input bit we, input logic [1:0] a, input logic [31:0] d,
                    output logic [31:0] rd, output int ack_e, output logic [3:0] strb,
                    output int start_e);
    @(negedge sys_clk);
    wbc_cyc_i = 1'b1; wbc_stb_i = 1'b1; wbc_we_i = we;
    wbc_adr_i = {$urandom() & 32'hFFFF_FFF0} | {28'b0, a, 2'b00};
    wbc_dat_i = d;
    start_e = edge_n + 1;
    ack_e = -1; rd = '0; strb = 4'hF;
    for (int i = 0; i < 400; i++) begin
      @(posedge sys_clk); #1;
      if (wbc_ack_o) begin
        ack_e = edge_n; rd = wbc_dat_o;
        strb = {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n};
        break;
      end
    end
    if (ack_e < 0) begin
      total++; bad++;
      $display("FAIL ack_timeout adr=%0d got no ack, required ack within 400 clocks", a);
    end
    @(negedge sys_clk);
    wbc_cyc_i = 1'b0; wbc_stb_i = 1'b0; wbc_we_i = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [31:0] rd; logic [3:0] s; int ae, se;
    sys_rst_n = 1'b0;
    wbc_adr_i = '0; wbc_dat_i = '0; wbc_sel_i = 4'hF;
    wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
    model_reset();
    repeat (3) @(negedge sys_clk);
    total++; if ({bypass, sdram_rst, sdram_cke} !== 3'b110) begin bad++;
      $display("FAIL rst_sys got=%b exp=110", {bypass, sdram_rst, sdram_cke}); end
    total++; if ({byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n} !== 4'hF) begin bad++;
      $display("FAIL rst_strobes got=%h exp=f", {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n}); end
    total++; if (wbc_ack_o !== 1'b0 || wbc_dat_o !== 32'h0) begin bad++;
      $display("FAIL rst_bus ack=%b dat=%h exp ack=0 dat=0", wbc_ack_o, wbc_dat_o); end
    total++; if ({tim_wr, tim_rfc, tim_refi, tim_rcd, tim_rp} !== m_tim) begin bad++;
      $display("FAIL rst_tim_out got=%h exp=%h", {tim_wr, tim_rfc, tim_refi, tim_rcd, tim_rp}, m_tim); end
    total++; if ({byp_adr, byp_ba} !== 15'h0) begin bad++;
      $display("FAIL rst_byp_adr got=%h exp=0", {byp_adr, byp_ba}); end
    sys_rst_n = 1'b1;
    wb(1'b0, 2'd2, 32'h0, rd, ae, s, se);
    total++; if (rd !== 32'h0050_B912) begin bad++;
      $display("FAIL rst_tim_read got=%h exp=%h", rd, 32'h0050_B912); end
  endtask

  task automatic test_sys_rw();
    logic [31:0] rd; logic [3:0] s; int ae, se;
    wb(1'b1, 2'd0, 32'h7, rd, ae, s, se);
    total++; if (ae !== se) begin bad++;
      $display("FAIL sys_ack_latency got_edge=%0d exp_edge=%0d", ae, se); end
    total++; if (sdram_cke !== 1'b0) begin bad++;
      $display("FAIL sys_cke_in_ack got=%b exp=0", sdram_cke); end
    @(posedge sys_clk); #1;
    total++; if (wbc_ack_o !== 1'b0) begin bad++;
      $display("FAIL sys_ack_width got=%b exp=0", wbc_ack_o); end
    total++; if ({bypass, sdram_rst, sdram_cke} !== 3'b111) begin bad++;
      $display("FAIL sys_after_ack got=%b exp=111", {bypass, sdram_rst, sdram_cke}); end
    model_write(2'd0, 32'h7, ae);
    wb(1'b0, 2'd0, 32'h0, rd, ae, s, se);
    total++; if (rd !== 32'h7) begin bad++;
      $display("FAIL sys_read got=%h exp=00000007", rd); end
  endtask

  task automatic test_precharge();
    logic [31:0] rd, d; logic [3:0] s; int ae, se;
    d = 32'h0002_000B;
    wb(1'b1, 2'd1, d, rd, ae, s, se);
    total++; if (ae !== imax(se, guard_free())) begin bad++;
      $display("FAIL pre_ack_edge got=%0d exp=%0d", ae, imax(se, guard_free())); end
    // cs_n/we_n/cas_n/ras_n are the inverses of data bits 0..3
    total++; if (s !== {!d[3], !d[2], !d[1], !d[0]}) begin bad++;
      $display("FAIL pre_strobes got=%b exp=%b", s, {!d[3], !d[2], !d[1], !d[0]}); end
    total++; if (byp_adr !== 13'((d >> 4) & 32'h1FFF) || byp_ba !== 2'((d >> 17) & 3)) begin bad++;
      $display("FAIL pre_adr_ba got=%h/%h exp=%h/%h", byp_adr, byp_ba,
               13'((d >> 4) & 32'h1FFF), 2'((d >> 17) & 3)); end
    model_write(2'd1, d, ae);
    @(posedge sys_clk); #1;
    total++; if ({byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n} !== 4'hF) begin bad++;
      $display("FAIL pre_strobe_release got=%b exp=1111", {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n}); end
    total++; if (byp_ba !== 2'((d >> 17) & 3)) begin bad++;
      $display("FAIL pre_ba_hold got=%h exp=%h", byp_ba, 2'((d >> 17) & 3)); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic [3:0] s, s1, s2; int ae, se, a1, a2, nack, pulses, exp1, exp2, tail;
    wb(1'b1, 2'd3, 32'h2, rd, ae, s, se);
    model_write(2'd3, 32'h2, ae);
    @(negedge sys_clk);
    wbc_cyc_i = 1; wbc_stb_i = 1; wbc_we_i = 1; wbc_adr_i = 32'h4; wbc_dat_i = 32'h1F;
    exp1 = imax(edge_n + 1, guard_free());
    nack = 0; pulses = 0; a1 = -1; a2 = -1; s1 = 4'hF; s2 = 4'hF; tail = 0;
    for (int i = 0; i < 60 && tail < 3; i++) begin
      @(posedge sys_clk); #1;
      if (!byp_cs_n) pulses++;
      if (nack == 2) tail++;
      if (wbc_ack_o) begin
        nack++;
        if (nack == 1) begin
          a1 = edge_n; s1 = {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n};
          model_write(2'd1, 32'h1F, a1);
          wbc_dat_i = 32'hD;
        end else begin
          a2 = edge_n; s2 = {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n};
          wbc_cyc_i = 0; wbc_stb_i = 0; wbc_we_i = 0;
        end
      end
    end
    exp2 = imax(a1 + 2, guard_free());
    model_write(2'd1, 32'hD, a2);
    total++; if (a1 !== exp1) begin bad++;
      $display("FAIL b2b_first_ack got=%0d exp=%0d", a1, exp1); end
    total++; if (a2 - a1 - 2 !== 1 || a2 !== exp2) begin bad++;
      $display("FAIL b2b_stall got_stall=%0d exp_stall=1 edge=%0d exp_edge=%0d", a2 - a1 - 2, a2, exp2); end
    total++; if (pulses !== 2) begin bad++;
      $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++; if (s1 !== 4'b0000 || s2 !== 4'b0010) begin bad++;
      $display("FAIL b2b_strobes got=%b,%b exp=0000,0010", s1, s2); end
  endtask

  task automatic test_bypass_off();
    logic [31:0] rd; logic [3:0] s; int ae, se, exp;
    wb(1'b1, 2'd0, 32'h4, rd, ae, s, se);
    model_write(2'd0, 32'h4, ae);
    @(posedge sys_clk); #1;
    total++; if ({bypass, sdram_rst, sdram_cke} !== 3'b001) begin bad++;
      $display("FAIL off_sys got=%b exp=001", {bypass, sdram_rst, sdram_cke}); end
    wb(1'b1, 2'd1, 32'hF, rd, ae, s, se);
    exp = imax(se, guard_free());
    total++; if (s !== 4'hF || ae !== exp) begin bad++;
      $display("FAIL off_no_pulse strobes=%b edge=%0d exp strobes=1111 edge=%0d", s, ae, exp); end
    model_write(2'd1, 32'hF, ae);
    wb(1'b0, 2'd1, 32'h0, rd, ae, s, se);
    total++; if (rd !== 32'hF) begin bad++;
      $display("FAIL off_byp_read got=%h exp=0000000f", rd); end
  endtask

  task automatic test_random();
    logic [31:0] rd, d, er; logic [3:0] s, es; logic [1:0] a; bit w; int ae, se, ee;
    for (int i = 0; i < 48; i++) begin
      w = 1'($urandom_range(0, 1));
      a = 2'($urandom_range(0, 3));
      d = $urandom();
      if (w && a == 2'd3) d[7:0] = 8'($urandom_range(0, 4));
      @(posedge sys_clk); #1;
      total++; if ({bypass, sdram_rst, sdram_cke} !== {m_sys[0], m_sys[1], m_sys[2]}) begin bad++;
        $display("FAIL rnd_sys_out i=%0d got=%b exp=%b", i, {bypass, sdram_rst, sdram_cke},
                 {m_sys[0], m_sys[1], m_sys[2]}); end
      total++; if ({tim_wr, tim_rfc, tim_refi, tim_rcd, tim_rp} !== m_tim) begin bad++;
        $display("FAIL rnd_tim_out i=%0d got=%h exp=%h", i,
                 {tim_wr, tim_rfc, tim_refi, tim_rcd, tim_rp}, m_tim); end
      es = (w && a == 2'd1 && m_sys[0]) ? {!d[3], !d[2], !d[1], !d[0]} : 4'hF;
      wb(w, a, d, rd, ae, s, se);
      ee = (w && a == 2'd1) ? imax(se, guard_free()) : se;
      total++; if (ae !== ee) begin bad++;
        $display("FAIL rnd_ack_edge i=%0d we=%0d adr=%0d got=%0d exp=%0d", i, w, a, ae, ee); end
      total++; if (s !== es) begin bad++;
        $display("FAIL rnd_strobes i=%0d got=%b exp=%b", i, s, es); end
      if (!w) begin
        er = exp_read(a, ae);
        total++; if (rd !== er) begin bad++;
          $display("FAIL rnd_read i=%0d adr=%0d got=%h exp=%h", i, a, rd, er); end
      end else begin
        model_write(a, d, ae);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic [3:0] s; int ae, se;
    wb(1'b1, 2'd0, 32'h1, rd, ae, s, se);
    model_write(2'd0, 32'h1, ae);
    wb(1'b1, 2'd3, 32'h0, rd, ae, s, se);
    model_write(2'd3, 32'h0, ae);
    @(posedge sys_clk); #1;
    wb(1'b1, 2'd1, 32'hF, rd, ae, s, se);
    total++; if (wbc_ack_o !== 1'b1 || byp_cs_n !== 1'b0) begin bad++;
      $display("FAIL mid_pre ack=%b cs_n=%b exp ack=1 cs_n=0", wbc_ack_o, byp_cs_n); end
    sys_rst_n = 1'b0;
    #1;
    total++; if (wbc_ack_o !== 1'b0 || {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n} !== 4'hF) begin bad++;
      $display("FAIL mid_async ack=%b strobes=%b exp ack=0 strobes=1111", wbc_ack_o,
               {byp_ras_n, byp_cas_n, byp_we_n, byp_cs_n}); end
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    model_reset();
    wb(1'b0, 2'd0, 32'h0, rd, ae, s, se);
    total++; if (rd !== 32'h3) begin bad++;
      $display("FAIL mid_sys_read got=%h exp=00000003", rd); end
    wb(1'b0, 2'd1, 32'h0, rd, ae, s, se);
    total++; if (rd !== 32'h0) begin bad++;
      $display("FAIL mid_byp_read got=%h exp=00000000", rd); end
    wb(1'b0, 2'd3, 32'h0, rd, ae, s, se);
    total++; if (rd !== exp_read(2'd3, ae)) begin bad++;
      $display("FAIL mid_stat_read got=%h exp=%h", rd, exp_read(2'd3, ae)); end
  endtask

  initial begin
    test_reset();
    test_sys_rw();
    test_precharge();
    test_back_to_back();
    test_bypass_off();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
